// File: rtl/shot_sequencer.sv
// shot_sequencer: turns one start strobe into nshot paced shot triggers for the DSP core.
// Optional per-shot completion timeout is compiled in with SHOT_SEQ_TIMEOUT_EN.
module shot_sequencer #(
    parameter int NSHOT_WIDTH    = 32,
    parameter int DELAY_WIDTH    = 24,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_stb_start,
    input  logic                   i_stb_abort,
    input  logic [NSHOT_WIDTH-1:0] i_nshot,
    input  logic [DELAY_WIDTH-1:0] i_delayaftertrig,
    input  logic [DELAY_WIDTH-1:0] i_shot_gap,
    input  logic                   i_resetacc_en,
    input  logic                   i_procdone,
    output logic                   o_shot_stb,
    output logic                   o_resetacc_stb,
    output logic [NSHOT_WIDTH-1:0] o_shotcnt,
    output logic                   o_lastshotdone,
    output logic                   o_busy,
    output logic                   o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLRACC,
        S_DELAY,
        S_FIRE,
        S_WAITDONE,
        S_GAP
    } state_t;

    state_t                 r_state;
    logic [NSHOT_WIDTH-1:0] r_nshot;
    logic [NSHOT_WIDTH-1:0] r_shotcnt;
    logic [DELAY_WIDTH-1:0] r_gap;
    logic [DELAY_WIDTH-1:0] r_cnt;
    logic                   r_procdone_d;
    logic                   r_shot_stb;
    logic                   r_resetacc_stb;
    logic                   r_lastshotdone;
    logic                   r_busy;
    logic                   r_timeout;

    logic                   w_pd_edge;
    logic [NSHOT_WIDTH-1:0] w_shotcnt_inc;
    logic                   w_to_hit;

    assign w_pd_edge     = i_procdone & ~r_procdone_d;
    assign w_shotcnt_inc = r_shotcnt + 1'b1;

`ifdef SHOT_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_tocnt;

    // Counts WAITDONE cycles; clearing outside WAITDONE restarts it on every entry.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_tocnt <= '0;
        end else if (r_state != S_WAITDONE) begin
            r_tocnt <= '0;
        end else begin
            r_tocnt <= r_tocnt + 1'b1;
        end
    end

    assign w_to_hit = (r_tocnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_to_hit         = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state        <= S_IDLE;
            r_nshot        <= '0;
            r_shotcnt      <= '0;
            r_gap          <= '0;
            r_cnt          <= '0;
            r_procdone_d   <= 1'b0;
            r_shot_stb     <= 1'b0;
            r_resetacc_stb <= 1'b0;
            r_lastshotdone <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_procdone_d   <= i_procdone;
            r_shot_stb     <= 1'b0;
            r_resetacc_stb <= 1'b0;
            // Abort outranks everything; in IDLE it only has to suppress a start.
            if (r_state != S_IDLE && i_stb_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_stb_start && !i_stb_abort && (i_nshot != '0)) begin
                            r_nshot        <= i_nshot;
                            r_gap          <= i_shot_gap;
                            r_cnt          <= i_delayaftertrig;
                            r_shotcnt      <= '0;
                            r_lastshotdone <= 1'b0;
                            r_timeout      <= 1'b0;
                            r_busy         <= 1'b1;
                            r_resetacc_stb <= i_resetacc_en;
                            r_state        <= S_CLRACC;
                        end
                    end
                    S_CLRACC: begin
                        r_state <= S_DELAY;
                    end
                    S_DELAY, S_GAP: begin
                        if (r_cnt == '0) begin
                            r_shot_stb <= 1'b1;
                            r_state    <= S_FIRE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_FIRE: begin
                        r_state <= S_WAITDONE;
                    end
                    S_WAITDONE: begin
                        if (w_pd_edge) begin
                            r_shotcnt <= w_shotcnt_inc;
                            if (w_shotcnt_inc == r_nshot) begin
                                r_lastshotdone <= 1'b1;
                                r_busy         <= 1'b0;
                                r_state        <= S_IDLE;
                            end else begin
                                r_cnt   <= r_gap;
                                r_state <= S_GAP;
                            end
                        end else if (w_to_hit) begin
                            r_timeout <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_shot_stb     = r_shot_stb;
    assign o_resetacc_stb = r_resetacc_stb;
    assign o_shotcnt      = r_shotcnt;
    assign o_lastshotdone = r_lastshotdone;
    assign o_busy         = r_busy;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: a timeline model predicts every pulse and run boundary,
// and a negedge monitor pops those predictions whenever the DUT shows activity.
`timescale 1ns/1ps
module tb_shot_sequencer;

    localparam int NW = 32;
    localparam int DW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          i_aresetn;
    logic          i_stb_start;
    logic          i_stb_abort;
    logic [NW-1:0] i_nshot;
    logic [DW-1:0] i_delayaftertrig;
    logic [DW-1:0] i_shot_gap;
    logic          i_resetacc_en;
    logic          i_procdone;
    logic          o_shot_stb;
    logic          o_resetacc_stb;
    logic [NW-1:0] o_shotcnt;
    logic          o_lastshotdone;
    logic          o_busy;
    logic          o_timeout;

    shot_sequencer #(
        .NSHOT_WIDTH   (NW),
        .DELAY_WIDTH   (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk           (clk),
        .i_aresetn       (i_aresetn),
        .i_stb_start     (i_stb_start),
        .i_stb_abort     (i_stb_abort),
        .i_nshot         (i_nshot),
        .i_delayaftertrig(i_delayaftertrig),
        .i_shot_gap      (i_shot_gap),
        .i_resetacc_en   (i_resetacc_en),
        .i_procdone      (i_procdone),
        .o_shot_stb      (o_shot_stb),
        .o_resetacc_stb  (o_resetacc_stb),
        .o_shotcnt       (o_shotcnt),
        .o_lastshotdone  (o_lastshotdone),
        .o_busy          (o_busy),
        .o_timeout       (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit shot;
        bit racc;
        bit busy;
        bit last;
        bit to;
        int cnt;
    } ev_t;

    ev_t expQ[$];
    int  cyc       = 0;
    int  checks    = 0;
    int  errors    = 0;
    int  modelCnt  = 0;
    bit  modelLast = 1'b0;
    bit  prevBusy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(int c, bit shot, bit racc, bit busy, bit last, bit to, int cnt);
        ev_t e;
        e.cyc = c; e.shot = shot; e.racc = racc; e.busy = busy;
        e.last = last; e.to = to; e.cnt = cnt;
        return e;
    endfunction

    // Any strobe or busy transition is an event the model must have predicted.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (o_shot_stb || o_resetacc_stb || (o_busy != prevBusy)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event cyc=%0d shot=%0b racc=%0b busy=%0b cnt=%0d required no event",
                         cyc, o_shot_stb, o_resetacc_stb, o_busy, o_shotcnt);
            end else begin
                e = expQ.pop_front();
                if (e.cyc != cyc || e.shot != o_shot_stb || e.racc != o_resetacc_stb ||
                    e.busy != o_busy || e.last != o_lastshotdone || e.to != o_timeout ||
                    e.cnt != int'(o_shotcnt)) begin
                    errors++;
                    $display("[TB] FAIL event got cyc=%0d shot=%0b racc=%0b busy=%0b last=%0b to=%0b cnt=%0d required cyc=%0d shot=%0b racc=%0b busy=%0b last=%0b to=%0b cnt=%0d",
                             cyc, o_shot_stb, o_resetacc_stb, o_busy, o_lastshotdone, o_timeout, o_shotcnt,
                             e.cyc, e.shot, e.racc, e.busy, e.last, e.to, e.cnt);
                end
            end
        end
        prevBusy = o_busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_busy"}, int'(o_busy), 0);
        checkOutput({name, "_shotcnt"}, int'(o_shotcnt), modelCnt);
        checkOutput({name, "_last"}, int'(o_lastshotdone), int'(modelLast));
    endtask

    // One run: the model lays out shot/procdone edge times, queues the expected events,
    // then replays procdone, a mid-run start with new settings, and an optional abort.
    task automatic applyStimulus(input int n, input int d, input int g, input bit en, input int pFix,
                                 input int abortAfter, input int holdShot, input bit noDone);
        int s[$];
        int tp[$];
        int w[$];
        int t0, a, p, e, endCyc, numDone, nFired;
        bit pd;
        t0 = cyc + 1;
        a  = -1;
        s.push_back(t0 + d + 2);
        for (int k = 0; k < n; k++) begin
            p = (pFix != 0) ? pFix : int'($urandom_range(2, 6));
            if (k > 0 && tp[k-1] + w[k-1] + 1 > s[k] + p) p = tp[k-1] + w[k-1] + 1 - s[k];
            tp.push_back(s[k] + p);
            w.push_back((holdShot == k + 1) ? g + 10 : int'($urandom_range(1, 2)));
            s.push_back(tp[k] + g + 1);
        end
        if (noDone) begin
            numDone = 0; nFired = 1; endCyc = s[0] + TO + 1;
        end else if (abortAfter > 0) begin
            numDone = abortAfter; nFired = abortAfter; a = tp[abortAfter-1] + 1; endCyc = a;
        end else begin
            numDone = n; nFired = n; endCyc = tp[n-1];
        end
        expQ.push_back(mkEv(t0, 1'b0, en, 1'b1, 1'b0, 1'b0, 0));
        for (int k = 0; k < nFired; k++)
            expQ.push_back(mkEv(s[k], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, k));
        expQ.push_back(mkEv(endCyc, 1'b0, 1'b0, 1'b0, (abortAfter == 0) && !noDone, noDone, numDone));
        i_nshot = NW'(n); i_delayaftertrig = DW'(d); i_shot_gap = DW'(g); i_resetacc_en = en;
        while (cyc < endCyc + 6) begin
            e  = cyc + 1;
            pd = 1'b0;
            for (int k = 0; k < numDone; k++)
                if (e >= tp[k] && e < tp[k] + w[k]) pd = 1'b1;
            i_procdone  = pd;
            i_stb_start = (e == t0) || (e == t0 + 3);
            i_stb_abort = (e == a);
            if (e == t0 + 3) begin
                i_nshot          = NW'($urandom_range(1, 9));
                i_delayaftertrig = DW'($urandom_range(0, 30));
                i_shot_gap       = DW'($urandom_range(0, 30));
            end
            tick();
        end
        i_stb_start = 1'b0;
        i_stb_abort = 1'b0;
        i_procdone  = 1'b0;
        modelCnt  = numDone;
        modelLast = (abortAfter == 0) && !noDone;
    endtask

    task automatic resetMidDelay();
        i_nshot = 3; i_delayaftertrig = 20; i_shot_gap = 1; i_resetacc_en = 1'b1;
        i_stb_start = 1'b1;
        expQ.push_back(mkEv(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        tick();
        i_stb_start = 1'b0;
        repeat (4) tick();
        expQ.push_back(mkEv(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        i_aresetn = 1'b0;
        #1;
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_shot", int'(o_shot_stb), 0);
        checkOutput("rst_racc", int'(o_resetacc_stb), 0);
        checkOutput("rst_cnt", int'(o_shotcnt), 0);
        checkOutput("rst_last", int'(o_lastshotdone), 0);
        checkOutput("rst_to", int'(o_timeout), 0);
        repeat (2) tick();
        i_aresetn = 1'b1;
        repeat (2) tick();
        modelCnt  = 0;
        modelLast = 1'b0;
    endtask

    initial begin
        int n, d, g, ab;
        bit en;
        i_aresetn = 1'b0; i_stb_start = 1'b0; i_stb_abort = 1'b0; i_nshot = '0;
        i_delayaftertrig = '0; i_shot_gap = '0; i_resetacc_en = 1'b0; i_procdone = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_shot", int'(o_shot_stb), 0);
        checkOutput("reset_racc", int'(o_resetacc_stb), 0);
        checkOutput("reset_cnt", int'(o_shotcnt), 0);
        checkOutput("reset_last", int'(o_lastshotdone), 0);
        checkOutput("reset_to", int'(o_timeout), 0);
        i_aresetn = 1'b1;
        tick();

        applyStimulus(3, 5, 2, 1'b1, 4, 0, 0, 1'b0);
        checkIdle("basic");

        i_nshot = '0; i_stb_start = 1'b1;
        tick();
        i_stb_start = 1'b0;
        repeat (5) tick();
        checkIdle("nshot0");

        i_nshot = 3; i_stb_start = 1'b1; i_stb_abort = 1'b1;
        tick();
        i_stb_start = 1'b0; i_stb_abort = 1'b0;
        repeat (10) tick();
        checkIdle("start_abort");

        applyStimulus(4, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'b1, 0, 0, 2, 1'b0);
        checkIdle("hold");

        applyStimulus(5, 3, 3, 1'b1, 0, 2, 0, 1'b0);
        checkIdle("abort");
        applyStimulus(2, 1, 1, 1'b0, 0, 0, 0, 1'b0);

        resetMidDelay();

        applyStimulus(3, 0, 0, 1'b0, 2, 0, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            n  = int'($urandom_range(1, 6));
            d  = int'($urandom_range(0, 8));
            g  = int'($urandom_range(0, 4));
            en = 1'($urandom_range(0, 1));
            ab = (n >= 2 && g >= 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : 0;
            applyStimulus(n, d, g, en, 0, ab, 0, 1'b0);
        end

`ifdef SHOT_SEQ_TIMEOUT_EN
        applyStimulus(2, 2, 1, 1'b1, 0, 0, 0, 1'b1);
        checkOutput("timeout_flag", int'(o_timeout), 1);
        applyStimulus(1, 1, 0, 1'b0, 0, 0, 0, 1'b0);
        checkOutput("timeout_cleared", int'(o_timeout), 0);
`endif

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_events got=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
